// File: rtl/buf_owner_arbiter.sv
// Round-robin ownership arbiter for one shared buffer/register resource.
// Grants one requester at a time, inserts a guard cycle between owners and can revoke a stuck owner.
module buf_owner_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int TIMEOUT_W  = 16,
   parameter int INIT_OWNER = 2
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         rel,
   input  logic [TIMEOUT_W-1:0]       timeout_cycles,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       owner_valid,
   output logic [$clog2(NUM_REQ)-1:0] owner_id,
   output logic [NUM_REQ-1:0]         revoke,
   output logic [7:0]                 revoke_cnt
);
   localparam int ID_W     = $clog2(NUM_REQ);
   localparam int CW       = ID_W + 1;
   localparam bit HAS_INIT = (INIT_OWNER < NUM_REQ);
   localparam int INIT_ID  = HAS_INIT ? INIT_OWNER : 0;
   localparam int INIT_PTR = HAS_INIT ? ((INIT_OWNER + 1) % NUM_REQ) : 0;
   localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [NUM_REQ-1:0] INIT_GRANT = HAS_INIT ? (ONE_HOT0 << INIT_ID) : {NUM_REQ{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_GAP     = 2'd2
   } state_t;

   localparam state_t INIT_STATE = HAS_INIT ? ST_GRANTED : ST_IDLE;

   state_t               state_r;
   logic [ID_W-1:0]      rr_ptr_r;
   logic [TIMEOUT_W-1:0] hold_cnt_r;
   logic                 pick_found_s;
   logic [ID_W-1:0]      pick_idx_s;
   logic [ID_W-1:0]      pick_next_s;
   logic                 own_rel_s;
   logic                 tmo_hit_s;

   // (base + step) modulo NUM_REQ; both operands are already below NUM_REQ
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input logic [ID_W-1:0] step);
      logic [CW-1:0] sum;
      sum = {1'b0, base} + {1'b0, step};
      return (sum >= CW'(NUM_REQ)) ? ID_W'(sum - CW'(NUM_REQ)) : sum[ID_W-1:0];
   endfunction

   // Round-robin pick: descending scan so the candidate nearest rr_ptr is written last
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pick_found_s = pick_found_s | req[wrap_add(rr_ptr_r, ID_W'(k))];
         pick_idx_s   = req[wrap_add(rr_ptr_r, ID_W'(k))] ? wrap_add(rr_ptr_r, ID_W'(k)) : pick_idx_s;
      end
   end

   assign pick_next_s = wrap_add(pick_idx_s, ID_W'(1));
   assign own_rel_s   = rel[owner_id];
   assign tmo_hit_s   = (timeout_cycles != {TIMEOUT_W{1'b0}}) &&
                        (hold_cnt_r == (timeout_cycles - TIMEOUT_W'(1)));

   // Ownership state machine; every output is a register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_r     <= INIT_STATE;
         grant       <= INIT_GRANT;
         owner_valid <= HAS_INIT;
         owner_id    <= ID_W'(INIT_ID);
         rr_ptr_r    <= ID_W'(INIT_PTR);
         hold_cnt_r  <= '0;
         revoke      <= '0;
         revoke_cnt  <= 8'd0;
      end else begin
         revoke <= '0;
         case (state_r)
            ST_IDLE: begin
               if (pick_found_s) begin
                  state_r     <= ST_GRANTED;
                  grant       <= ONE_HOT0 << pick_idx_s;
                  owner_valid <= 1'b1;
                  owner_id    <= pick_idx_s;
                  hold_cnt_r  <= '0;
                  rr_ptr_r    <= pick_next_s;
               end
            end
            ST_GRANTED: begin
               hold_cnt_r <= (hold_cnt_r == {TIMEOUT_W{1'b1}}) ? hold_cnt_r : hold_cnt_r + TIMEOUT_W'(1);
               // An explicit release beats a timeout landing on the same cycle
               if (own_rel_s) begin
                  state_r     <= ST_GAP;
                  grant       <= '0;
                  owner_valid <= 1'b0;
                  owner_id    <= '0;
               end else if (tmo_hit_s) begin
                  state_r     <= ST_GAP;
                  grant       <= '0;
                  owner_valid <= 1'b0;
                  owner_id    <= '0;
                  revoke      <= grant;
                  revoke_cnt  <= (revoke_cnt == 8'hFF) ? revoke_cnt : revoke_cnt + 8'd1;
               end
            end
            ST_GAP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r     <= ST_IDLE;
               grant       <= '0;
               owner_valid <= 1'b0;
               owner_id    <= '0;
            end
         endcase
      end
   end

endmodule
